// File: rtl/ex_muldiv_sched.sv
// Multiply/divide scheduler beside EX: owns HI/LO, runs a fixed-latency multiplier and a
// 32-step restoring divider, and stalls younger HI/LO users while an operation is in flight.
//
// state | meaning
// IDLE  | no operation in flight; accepts MUL/DIV, performs MTHI/MTLO
// MUL   | counting down the multiplier latency, product written when counter is 0
// DIV   | one quotient bit per cycle while counter != 0, then fixup and write
module ex_muldiv_sched #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_Valid,
  input  logic [2:0]  EX_MulDivOp,
  input  logic [1:0]  EX_ReadHiLo,
  input  logic [31:0] EX_RsData,
  input  logic [31:0] EX_RtData,
  input  logic        Flush,
  output logic        MD_Stall,
  output logic        MD_Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HiLoOut
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} stateT;

  stateT       state, stateNext;
  logic [5:0]  cnt;
  logic [63:0] work;
  logic [31:0] rsQ, rtQ;
  logic        signedQ;

  logic req, isMul, isDiv, isMtHi, isMtLo, isSignedOp, accept;
  logic mulDone, divDone;

  assign req        = EX_Valid & ~Flush;
  assign isMul      = (EX_MulDivOp == 3'b001) | (EX_MulDivOp == 3'b010);
  assign isDiv      = (EX_MulDivOp == 3'b011) | (EX_MulDivOp == 3'b100);
  assign isMtHi     = (EX_MulDivOp == 3'b101);
  assign isMtLo     = (EX_MulDivOp == 3'b110);
  assign isSignedOp = (EX_MulDivOp == 3'b001) | (EX_MulDivOp == 3'b011);
  assign accept     = (state == IDLE) & req & (isMul | isDiv);

  assign MD_Busy  = (state != IDLE);
  assign MD_Stall = req & MD_Busy & ((EX_MulDivOp != 3'b000 && EX_MulDivOp != 3'b111) |
                                     (EX_ReadHiLo == 2'b01) | (EX_ReadHiLo == 2'b10));

  always_comb begin
    HiLoOut = 32'h0;
    case (EX_ReadHiLo)
      2'b01:   HiLoOut = HI;
      2'b10:   HiLoOut = LO;
      default: HiLoOut = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    mulDone   = 1'b0;
    divDone   = 1'b0;
    case (state)
      IDLE: if (accept) stateNext = isMul ? MUL : DIV;
      MUL:  if (cnt == 6'd0) begin stateNext = IDLE; mulDone = 1'b1; end
      DIV:  if (cnt == 6'd0) begin stateNext = IDLE; divDone = 1'b1; end
      default: stateNext = IDLE;
    endcase
  end

  // Sign/zero extension to 64 bits makes one unsigned multiply serve both MULT and MULTU.
  logic [63:0] mulA, mulB, product;
  assign mulA    = {{32{signedQ & rsQ[31]}}, rsQ};
  assign mulB    = {{32{signedQ & rtQ[31]}}, rtQ};
  assign product = mulA * mulB;

  logic [31:0] dividendAbs, divisorAbs, qRaw, rRaw, qFix, rFix;
  logic [32:0] remShift, diff;
  assign dividendAbs = (isSignedOp & EX_RsData[31]) ? -EX_RsData : EX_RsData;
  assign divisorAbs  = (signedQ & rtQ[31]) ? -rtQ : rtQ;
  assign remShift    = work[63:31];
  assign diff        = remShift - {1'b0, divisorAbs};
  assign qRaw        = work[31:0];
  assign rRaw        = work[63:32];

  always_comb begin
    qFix = (signedQ & (rsQ[31] ^ rtQ[31])) ? -qRaw : qRaw;
    rFix = (signedQ & rsQ[31]) ? -rRaw : rRaw;
    if (rtQ == 32'h0) begin
      qFix = 32'hFFFF_FFFF;
      rFix = rsQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 6'd0;
      work    <= 64'h0;
      rsQ     <= 32'h0;
      rtQ     <= 32'h0;
      signedQ <= 1'b0;
      HI      <= 32'h0;
      LO      <= 32'h0;
    end else begin
      if (accept) begin
        rsQ     <= EX_RsData;
        rtQ     <= EX_RtData;
        signedQ <= isSignedOp;
        cnt     <= isMul ? 6'(MUL_CYCLES - 1) : 6'd32;
        work    <= {32'h0, dividendAbs};
      end else if (state == MUL && cnt != 6'd0) begin
        cnt <= cnt - 6'd1;
      end else if (state == DIV && cnt != 6'd0) begin
        cnt <= cnt - 6'd1;
        if (!diff[32]) work <= {diff[31:0], work[30:0], 1'b1};
        else           work <= {work[62:0], 1'b0};
      end

      if (mulDone) begin
        HI <= product[63:32];
        LO <= product[31:0];
      end
      if (divDone) begin
        HI <= rFix;
        LO <= qFix;
      end
      if (state == IDLE && req && isMtHi) HI <= EX_RsData;
      if (state == IDLE && req && isMtLo) LO <= EX_RsData;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_sched.sv
// Directed bench for ex_muldiv_sched: latency, results, stall window, flush and reset.
module tb_ex_muldiv_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        EX_Valid;
  logic [2:0]  EX_MulDivOp;
  logic [1:0]  EX_ReadHiLo;
  logic [31:0] EX_RsData, EX_RtData;
  logic        Flush;
  logic        MD_Stall, MD_Busy;
  logic [31:0] HI, LO, HiLoOut;

  int tests = 0;
  int errs  = 0;
  int n;

  localparam logic [2:0] OP_NONE = 3'b000, OP_MULT = 3'b001, OP_MULTU = 3'b010,
                         OP_DIV = 3'b011, OP_DIVU = 3'b100, OP_MTHI = 3'b101,
                         OP_MTLO = 3'b110, OP_RSVD = 3'b111;

  ex_muldiv_sched #(.MUL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .EX_Valid(EX_Valid), .EX_MulDivOp(EX_MulDivOp),
    .EX_ReadHiLo(EX_ReadHiLo), .EX_RsData(EX_RsData), .EX_RtData(EX_RtData),
    .Flush(Flush), .MD_Stall(MD_Stall), .MD_Busy(MD_Busy), .HI(HI), .LO(LO),
    .HiLoOut(HiLoOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    EX_Valid = 1'b0; EX_MulDivOp = OP_NONE; EX_ReadHiLo = 2'b00;
    EX_RsData = 32'h0; EX_RtData = 32'h0; Flush = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    EX_Valid = 1'b1; EX_MulDivOp = op; EX_RsData = rs; EX_RtData = rt;
  endtask

  // Issue one op, then count cycles with MD_Busy high (bounded).
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int cycles);
    drive(op, rs, rt);
    step();
    idleInputs();
    cycles = 0;
    while (MD_Busy && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  task automatic countStall(output int cycles);
    cycles = 0;
    while (MD_Stall && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("reset_busy", 32'(MD_Busy), 32'd0);
    check("reset_stall", 32'(MD_Stall), 32'd0);
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);

    // 1: multiply latency and signed/unsigned products
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, n);
    check("mult_busy_cycles", 32'(n), 32'd4);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, n);
    check("multu_busy_cycles", 32'(n), 32'd4);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    // 2: divide latency and signed fixup
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    check("div_busy_cycles", 32'(n), 32'd33);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'd7, 32'd2, n);
    check("divu_busy_cycles", 32'(n), 32'd33);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);
    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, n);
    check("divu_big_lo", LO, 32'h7FFF_FFFC);
    check("divu_big_hi", HI, 32'd1);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, n);
    check("div_negdivisor_lo", LO, 32'hFFFF_FFFD);
    check("div_negdivisor_hi", HI, 32'd1);

    // 4: divide by zero and overflow case
    issue(OP_DIV, 32'd5, 32'd0, n);
    check("div0_busy_cycles", 32'(n), 32'd33);
    check("div0_hi", HI, 32'd5);
    check("div0_lo", LO, 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'hFFFF_FFF0, 32'd0, n);
    check("divu0_hi", HI, 32'hFFFF_FFF0);
    check("divu0_lo", LO, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);

    // 3: MFHI right behind MULT stalls for the whole latency
    drive(OP_MULT, 32'h0001_0001, 32'h0001_0000);
    step();
    idleInputs();
    EX_Valid = 1'b1; EX_ReadHiLo = 2'b01;
    countStall(n);
    check("mfhi_stall_cycles", 32'(n), 32'd4);
    check("mfhi_stall_low", 32'(MD_Stall), 32'd0);
    check("mfhi_value", HiLoOut, 32'h0000_0001);
    EX_ReadHiLo = 2'b10;
    #1 check("mflo_value", HiLoOut, 32'h0001_0000);
    EX_ReadHiLo = 2'b11;
    #1 check("readhilo_11_value", HiLoOut, 32'h0);
    idleInputs();
    step();

    // 5: DIV right behind MULT waits, then is accepted
    drive(OP_MULT, 32'd3, 32'd4);
    step();
    drive(OP_DIV, 32'd100, 32'd7);
    countStall(n);
    check("div_after_mult_stall", 32'(n), 32'd4);
    check("div_after_mult_lo_mul", LO, 32'd12);
    step();
    idleInputs();
    check("div_after_mult_accepted", 32'(MD_Busy), 32'd1);
    n = 0;
    while (MD_Busy && n < 100) begin n++; step(); end
    check("div_after_mult_busy", 32'(n), 32'd33);
    check("div_after_mult_lo", LO, 32'd14);
    check("div_after_mult_hi", HI, 32'd2);

    drive(OP_MULT, 32'd5, 32'd6);
    step();
    drive(OP_MTLO, 32'h0000_1234, 32'h0);
    countStall(n);
    check("mtlo_stall_cycles", 32'(n), 32'd4);
    check("mtlo_lo_before", LO, 32'd30);
    step();
    idleInputs();
    check("mtlo_lo_after", LO, 32'h0000_1234);
    check("mtlo_hi_after", HI, 32'h0);
    check("mtlo_busy", 32'(MD_Busy), 32'd0);

    // 6: reset mid-divide discards the result
    drive(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
    step();
    idleInputs();
    repeat (4) step();
    check("pre_reset_hi", HI, 32'h0000_0003);
    drive(OP_DIVU, 32'd100, 32'd7);
    step();
    idleInputs();
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_busy", 32'(MD_Busy), 32'd0);
    check("midreset_hi", HI, 32'h0);
    check("midreset_lo", LO, 32'h0);
    repeat (30) step();
    check("midreset_no_late_hi", HI, 32'h0);
    check("midreset_no_late_lo", LO, 32'h0);

    // Flush and reserved ops
    drive(OP_MTHI, 32'h0000_ABCD, 32'h0);
    step();
    idleInputs();
    check("mthi_hi", HI, 32'h0000_ABCD);
    check("mthi_busy", 32'(MD_Busy), 32'd0);
    drive(OP_MULT, 32'd2, 32'd3);
    Flush = 1'b1;
    step();
    idleInputs();
    check("flush_mult_busy", 32'(MD_Busy), 32'd0);
    repeat (5) step();
    check("flush_mult_hi", HI, 32'h0000_ABCD);
    check("flush_mult_lo", LO, 32'h0);
    drive(OP_MTLO, 32'h5555_5555, 32'h0);
    Flush = 1'b1;
    step();
    idleInputs();
    check("flush_mtlo_lo", LO, 32'h0);
    drive(OP_RSVD, 32'h7777_7777, 32'd9);
    step();
    idleInputs();
    check("rsvd_busy", 32'(MD_Busy), 32'd0);
    check("rsvd_hi", HI, 32'h0000_ABCD);

    drive(OP_MULT, 32'd2, 32'd3);
    step();
    idleInputs();
    EX_Valid = 1'b1; EX_ReadHiLo = 2'b01; Flush = 1'b1;
    #1 check("flush_blocks_stall", 32'(MD_Stall), 32'd0);
    Flush = 1'b0;
    #1 check("stall_without_flush", 32'(MD_Stall), 32'd1);
    idleInputs();
    repeat (5) step();
    check("flush_then_mult_lo", LO, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ex_muldiv_sched.md
Name: ex_muldiv_sched

Overview:
- Multi-cycle multiply/divide scheduler beside the EX stage; owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the instruction in EX.
- Sequences the iterative divider and the fixed-latency multiplier.
- Raises a pipeline stall when a later HI/LO consumer or producer reaches EX while an operation is in flight. The issuing instruction itself never stalls; it proceeds to MEM.

Parameters:
MUL_CYCLES, 4, cycles from multiply accept to HI/LO write; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
EX_Valid  in  1  EX holds a real instruction (not a bubble)
EX_MulDivOp  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
EX_ReadHiLo  in  2  00 none, 01 MFHI, 10 MFLO, 11 treated as none
EX_RsData  in  32  forwarded rs operand (dividend / multiplicand / MTHI-MTLO source)
EX_RtData  in  32  forwarded rt operand (divisor / multiplier)
Flush  in  1  EX instruction is being squashed this cycle
MD_Stall  out  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM
MD_Busy  out  1  operation in flight
HI  out  32  HI register
LO  out  32  LO register
HiLoOut  out  32  MFHI/MFLO result for the EX_MEM ALUOut mux

Behaviour:
- FSM states: IDLE, MUL, DIV. A 6-bit counter and a 64-bit working register are internal.
- req = EX_Valid & !Flush.
- Accept condition: state IDLE, req, and op in {MULT, MULTU, DIV, DIVU}.
  - Operands are latched at that edge (accept edge E0).
  - MUL: counter loaded with MUL_CYCLES-1.
  - DIV: counter loaded with 32.
- MUL state:
  - The 64-bit product is computed from the latched operands: signed for MULT, unsigned for MULTU.
  - Counter decrements each cycle.
  - At the edge where the counter reaches 0, {HI,LO} = product and the FSM returns to IDLE. That edge is E0+MUL_CYCLES.
- DIV state:
  - Restoring division on absolute values (DIV) or raw values (DIVU): 32 iterations, one bit per cycle.
  - One additional fixup cycle follows the iterations.
  - Signed fixup: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - LO = quotient, HI = remainder, written at edge E0+33; FSM returns to IDLE.
- Divide by zero: HI = dividend, LO = 32'hFFFFFFFF, for both signed and unsigned. Timing is still 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, with no trap.
- MD_Busy = (state != IDLE), registered. It is high for exactly MUL_CYCLES or 33 cycles after E0 and falls at the same edge that writes HI/LO.
- MTHI/MTLO, only when IDLE and req: HI or LO (respectively) = EX_RsData at that edge. Single cycle, MD_Busy stays 0.
- MD_Stall (combinational) = req & MD_Busy & (EX_MulDivOp in {001..110} | EX_ReadHiLo in {01,10}).
  - The stalled instruction is accepted or read in the first cycle with MD_Busy=0.
- HiLoOut = HI when EX_ReadHiLo==01, LO when 10, otherwise 0. It reads the registers directly; no bypass is needed because the write edge precedes the first non-busy cycle.
- Flush:
  - Blocks accept, MTHI/MTLO writes and MD_Stall in that cycle.
  - Never aborts an in-flight operation, because the issuer is older and committed.
- Reserved or none ops with EX_Valid: no effect.
- Reset (any state, including mid-operation): state IDLE, counter 0, HI = LO = 0, MD_Busy = 0.
  - MD_Stall = 0 whenever MD_Busy = 0.
  - The pending result is discarded and never written.
- HI/LO change only at result-write edges, MTHI/MTLO edges, or reset.

Test Plan:
1. MULT EX_RsData=0xFFFFFFFE, EX_RtData=3, MUL_CYCLES=4 -> MD_Busy high 4 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
2. DIV -7 (0xFFFFFFF9) / 2 -> MD_Busy high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
3. MFHI enters EX the cycle after a MULT accept -> MD_Stall high exactly 4 cycles; in the 5th cycle HiLoOut equals the new HI and MD_Stall=0.
4. DIV 5/0 -> HI=5, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
5. MULT immediately followed by DIV -> DIV stalled 4 cycles and accepted in the cycle MD_Busy=0; final LO/HI equal the DIV result. MTLO 0x1234 while busy -> stalled, then LO=0x1234 one edge after the stall ends.
6. Reset asserted on cycle 10 of a DIV -> next cycle MD_Busy=0, HI=LO=0, and no write occurs at E0+33. MULT in EX with Flush=1 -> not accepted, MD_Busy stays 0, HI/LO unchanged.
